fetch_stage_hs: RTL and testbench
=================================

Name: fetch_stage_hs

Overview:
- Parametrised next-generation IF stage plus IF/ID pipeline register for the RISC-V pipeline.
- Fetches over a request/response instruction-memory handshake that allows variable latency, with one request outstanding at a time.
- Supports redirect from EX, decode stall and decode flush, and drives a validD qualifier into decode.
- Sustains one instruction per cycle when memory latency is 1 cycle.

Parameters:
- XLEN, 32, width of PC and address buses.
- ILEN, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value loaded into instrD on bubble, flush or reset.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pcsrcE  input  1  redirect request from EX.
- pctargetE  input  XLEN  redirect target.
- stallD  input  1  IF/ID must hold its contents.
- flushD  input  1  IF/ID must become a bubble.
- imem_req  output  1  request strobe; memory accepts it in the same cycle.
- imem_addr  output  XLEN  request address; valid only while imem_req=1.
- imem_rvalid  input  1  response valid, at least 1 cycle after the request.
- imem_rdata  input  ILEN  response instruction.
- instrD  output  ILEN  IF/ID instruction.
- pcD  output  XLEN  IF/ID PC.
- pcplus4D  output  XLEN  IF/ID PC+4.
- validD  output  1  IF/ID holds a real instruction.

Behaviour:
- Internal state: pcF (XLEN), FSM state {FETCH, WAIT, HOLD}, kill flag, hold buffer (ILEN).
- Reset (rst=1 at a clock edge): state=FETCH, pcF=RESET_PC, kill=0, buffer cleared, instrD=NOP_INSTR, pcD=0, pcplus4D=0, validD=0.
- imem_req is forced to 0 while rst=1.
- Instruction memory shares rst, so no response survives reset.
- FETCH: imem_req=1, imem_addr=pcF; next state WAIT. imem_rvalid is ignored in this state.
- WAIT, no imem_rvalid: imem_req=0; stay in WAIT.
- WAIT, imem_rvalid=1 with kill=1: drop the response, clear kill, go to FETCH.
- WAIT, imem_rvalid=1 with kill=0 and stallD=0: IF/ID loads {imem_rdata, pcF, pcF+4, validD=1}; pcF<=pcF+4; imem_req=1, imem_addr=pcF+4 in the same cycle; stay in WAIT (back-to-back).
- WAIT, imem_rvalid=1 with kill=0 and stallD=1: buffer<=imem_rdata; go to HOLD; imem_req=0.
- HOLD: imem_req=0 while stallD=1.
- HOLD, stallD=0: IF/ID loads {buffer, pcF, pcF+4, 1}; pcF<=pcF+4; imem_req=1, imem_addr=pcF+4; go to WAIT.
- Redirect (pcsrcE=1) has highest priority in every state:
  - imem_req=0 that cycle; pcF<=pctargetE; buffer discarded.
  - In WAIT with no response this cycle: kill<=1, stay in WAIT.
  - In WAIT with kill already set: kill stays 1.
  - Otherwise: go to FETCH.
  - A response arriving in the same cycle as the redirect is dropped.
  - IF/ID does not load a fetched instruction that cycle.
- IF/ID update priority, highest first:
  - rst.
  - flushD: bubble of {NOP_INSTR, 0, 0, validD=0}.
  - stallD: hold all fields.
  - Load as above.
  - Otherwise bubble.
- flushD has priority over stallD.
- pcF+4 wraps modulo 2^XLEN; no alignment checks.
- imem_rvalid in FETCH or HOLD is a protocol error; it must not change state.

Test Plan:
- Reset: RESET_PC=0x100; hold rst 3 cycles -> validD=0, instrD=0x13, imem_req=0 throughout; first cycle after release imem_req=1, imem_addr=0x100.
- Streaming, 1-cycle memory returning addr-dependent data -> imem_addr 0x100, 0x104, 0x108, 0x10C on consecutive cycles; pcD follows one cycle after each response; pcplus4D=pcD+4; validD=1 continuously.
- Stall: stallD=1 for 3 cycles starting at the response for 0x104 -> IF/ID holds 0x100, imem_req=0 during HOLD; on release, pcD=0x104 with the correct instrD, next imem_addr=0x108.
- Redirect during latency: 3-cycle memory, pcsrcE=1 with pctargetE=0x200 one cycle after the request for 0x108 -> stale response dropped, next imem_addr=0x200, pcD never equals 0x108.
- Simultaneous events: imem_rvalid, stallD and pcsrcE (target 0x300) in the same cycle -> response dropped, state FETCH, next imem_addr=0x300, buffer not used.
- Flush: flushD=1 together with stallD=1 -> next cycle validD=0, instrD=0x13, pcD=0, pcplus4D=0.
- Wrap: pcF=0xFFFF_FFFC streaming -> pcplus4D=0, next imem_addr=0x0.

Source files
------------

// File: rtl/fetch_stage_hs_if.sv
// Bundle of the fetch-stage handshake signals: EX redirect, decode control,
// instruction-memory request/response and the IF/ID register outputs.
interface fetch_stage_hs_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            pcsrcE;
    logic [XLEN-1:0] pctargetE;
    logic            stallD;
    logic            flushD;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic [ILEN-1:0] instrD;
    logic [XLEN-1:0] pcD;
    logic [XLEN-1:0] pcplus4D;
    logic            validD;

    // Fetch-stage side.
    modport master (
        input  pcsrcE, pctargetE, stallD, flushD, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, instrD, pcD, pcplus4D, validD
    );

    // Environment side: EX/decode control plus instruction memory.
    modport slave (
        output pcsrcE, pctargetE, stallD, flushD, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, instrD, pcD, pcplus4D, validD
    );
endinterface

// File: rtl/fetch_stage_hs.sv
// IF stage with a variable-latency request/response instruction fetch
// (one request outstanding) and the IF/ID pipeline register.
module fetch_stage_hs #(
    parameter int                 XLEN      = 32,
    parameter int                 ILEN      = 32,
    parameter logic [XLEN-1:0]    RESET_PC  = '0,
    parameter logic [ILEN-1:0]    NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    fetch_stage_hs_if.master  bus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic [ILEN-1:0] buf_q, buf_d;

    logic [ILEN-1:0] instr_q;
    logic [XLEN-1:0] pcd_q;
    logic [XLEN-1:0] pc4d_q;
    logic            valid_q;

    logic [XLEN-1:0] pc_plus4;
    logic            req;
    logic [XLEN-1:0] addr;
    logic            load;
    logic [ILEN-1:0] load_instr;

    assign pc_plus4 = pc_q + XLEN'(4);

    // Next-state, request and IF/ID load decision; redirect overrides everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        buf_d      = buf_q;
        req        = 1'b0;
        addr       = pc_q;
        load       = 1'b0;
        load_instr = bus.imem_rdata;

        if (bus.pcsrcE) begin
            pc_d = bus.pctargetE;
            if (state_q == S_WAIT && !bus.imem_rvalid) begin
                // Request still in flight: its response must be discarded later.
                kill_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                // Nothing outstanding (or response dropped now): refetch at once.
                kill_d  = 1'b0;
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    req     = 1'b1;
                    addr    = pc_q;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_FETCH;
                        end else if (!bus.stallD) begin
                            // Back-to-back: deliver and request the next word this cycle.
                            load = 1'b1;
                            pc_d = pc_plus4;
                            req  = 1'b1;
                            addr = pc_plus4;
                        end else begin
                            buf_d   = bus.imem_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!bus.stallD) begin
                        load       = 1'b1;
                        load_instr = buf_q;
                        pc_d       = pc_plus4;
                        req        = 1'b1;
                        addr       = pc_plus4;
                        state_d    = S_WAIT;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign bus.imem_req  = req & ~rst;
    assign bus.imem_addr = addr;

    // Fetch FSM, PC, kill flag and hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            buf_q   <= buf_d;
        end
    end

    // IF/ID register: reset > flush > stall > load > bubble.
    always_ff @(posedge clk) begin
        if (rst || bus.flushD) begin
            instr_q <= NOP_INSTR;
            pcd_q   <= '0;
            pc4d_q  <= '0;
            valid_q <= 1'b0;
        end else if (bus.stallD) begin
            instr_q <= instr_q;
            pcd_q   <= pcd_q;
            pc4d_q  <= pc4d_q;
            valid_q <= valid_q;
        end else if (load) begin
            instr_q <= load_instr;
            pcd_q   <= pc_q;
            pc4d_q  <= pc_plus4;
            valid_q <= 1'b1;
        end else begin
            instr_q <= NOP_INSTR;
            pcd_q   <= '0;
            pc4d_q  <= '0;
            valid_q <= 1'b0;
        end
    end

    assign bus.instrD   = instr_q;
    assign bus.pcD      = pcd_q;
    assign bus.pcplus4D = pc4d_q;
    assign bus.validD   = valid_q;

endmodule

// File: tb/tb_fetch_stage_hs.sv
// Bench for fetch_stage_hs: directed scenarios plus a randomized run checked
// against an in-order instruction-stream scoreboard with a latency-randomized memory.
module tb_fetch_stage_hs;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_stage_hs_if #(.XLEN(32), .ILEN(32)) bus_if ();

    fetch_stage_hs #(
        .XLEN(32), .ILEN(32), .RESET_PC(32'h0000_0100), .NOP_INSTR(NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model state
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          mem_lat;
    logic        lat_rand;

    // Pre-edge samples of the current cycle
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_rv;
    logic        s_pend;

    function automatic logic [31:0] idata(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hC0DE_0001;
    endfunction

    // One clock cycle: present memory response, sample request, clock, update memory.
    task automatic tick();
        bus_if.imem_rvalid = mem_pend && (mem_cnt == 0);
        bus_if.imem_rdata  = bus_if.imem_rvalid ? idata(mem_addr) : $urandom;
        #1;
        s_req  = bus_if.imem_req;
        s_addr = bus_if.imem_addr;
        s_rv   = bus_if.imem_rvalid;
        s_pend = mem_pend;
        @(posedge clk);
        #1;
        if (rst) begin
            mem_pend = 1'b0;
        end else begin
            if (s_rv) mem_pend = 1'b0;
            else if (mem_pend && mem_cnt != 0) mem_cnt = mem_cnt - 1;
            if (s_req) begin
                mem_pend = 1'b1;
                mem_addr = s_addr;
                mem_cnt  = lat_rand ? int'($urandom_range(0, 3)) : mem_lat - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.pcsrcE = 1'b0; bus_if.pctargetE = '0;
        bus_if.stallD = 1'b0; bus_if.flushD = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_req !== 1'b0) begin
                failures++; $display("FAIL reset_req cyc=%0d got=%b want=0", i, s_req);
            end
            checks++;
            if ({bus_if.validD, bus_if.instrD, bus_if.pcD, bus_if.pcplus4D} !== {1'b0, NOP, 32'h0, 32'h0}) begin
                failures++;
                $display("FAIL reset_ifid cyc=%0d got v=%b i=%h pc=%h pc4=%h want v=0 i=%h pc=0 pc4=0",
                         i, bus_if.validD, bus_if.instrD, bus_if.pcD, bus_if.pcplus4D, NOP);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({s_req, s_addr} !== {1'b1, 32'h100}) begin
            failures++; $display("FAIL reset_first_req got req=%b addr=%h want req=1 addr=00000100", s_req, s_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({s_req, s_addr} !== {1'b1, 32'h100 + 32'(4 * i)}) begin
                failures++; $display("FAIL stream_req i=%0d got req=%b addr=%h want addr=%h",
                                     i, s_req, s_addr, 32'h100 + 32'(4 * i));
            end
            if (i >= 1) begin
                checks++;
                if ({bus_if.validD, bus_if.pcD, bus_if.instrD, bus_if.pcplus4D} !==
                    {1'b1, 32'h100 + 32'(4 * (i - 1)), idata(32'h100 + 32'(4 * (i - 1))), 32'h100 + 32'(4 * i)}) begin
                    failures++; $display("FAIL stream_ifid i=%0d got v=%b pc=%h i=%h pc4=%h want pc=%h",
                                         i, bus_if.validD, bus_if.pcD, bus_if.instrD, bus_if.pcplus4D,
                                         32'h100 + 32'(4 * (i - 1)));
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        mem_lat = 1;
        tick();  // request 0x100
        tick();  // response 0x100, request 0x104
        checks++;
        if ({bus_if.validD, bus_if.pcD} !== {1'b1, 32'h100}) begin
            failures++; $display("FAIL stall_pre got v=%b pc=%h want v=1 pc=00000100", bus_if.validD, bus_if.pcD);
        end
        bus_if.stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_req !== 1'b0) begin
                failures++; $display("FAIL stall_req cyc=%0d got=%b want=0", i, s_req);
            end
            checks++;
            if ({bus_if.validD, bus_if.pcD, bus_if.instrD} !== {1'b1, 32'h100, idata(32'h100)}) begin
                failures++; $display("FAIL stall_hold cyc=%0d got v=%b pc=%h i=%h want pc=00000100 i=%h",
                                     i, bus_if.validD, bus_if.pcD, bus_if.instrD, idata(32'h100));
            end
        end
        bus_if.stallD = 1'b0;
        tick();
        checks++;
        if ({s_req, s_addr} !== {1'b1, 32'h108}) begin
            failures++; $display("FAIL stall_release_req got req=%b addr=%h want addr=00000108", s_req, s_addr);
        end
        checks++;
        if ({bus_if.validD, bus_if.pcD, bus_if.instrD, bus_if.pcplus4D} !== {1'b1, 32'h104, idata(32'h104), 32'h108}) begin
            failures++; $display("FAIL stall_release_ifid got v=%b pc=%h i=%h pc4=%h want pc=00000104 i=%h",
                                 bus_if.validD, bus_if.pcD, bus_if.instrD, bus_if.pcplus4D, idata(32'h104));
        end
    endtask

    task automatic test_redirect();
        logic        found, saw108, got_req, got_pc;
        logic [31:0] first_addr, inst;
        do_reset();
        mem_lat = 3;
        found = 1'b0; saw108 = 1'b0; got_req = 1'b0; got_pc = 1'b0;
        first_addr = '0; inst = '0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (s_req && s_addr == 32'h108) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            failures++; $display("FAIL redir_req108 got found=%b want 1", found);
        end
        bus_if.pcsrcE = 1'b1; bus_if.pctargetE = 32'h200;
        tick();
        bus_if.pcsrcE = 1'b0;
        checks++;
        if (s_req !== 1'b0) begin
            failures++; $display("FAIL redir_req_during got=%b want=0", s_req);
        end
        if (bus_if.validD && bus_if.pcD == 32'h108) saw108 = 1'b1;
        for (int i = 0; i < 40 && !got_pc; i++) begin
            tick();
            if (bus_if.validD && bus_if.pcD == 32'h108) saw108 = 1'b1;
            if (s_req && !got_req) begin got_req = 1'b1; first_addr = s_addr; end
            if (bus_if.validD && bus_if.pcD == 32'h200) begin got_pc = 1'b1; inst = bus_if.instrD; end
        end
        checks++;
        if ({got_req, first_addr} !== {1'b1, 32'h200}) begin
            failures++; $display("FAIL redir_next_req got req=%b addr=%h want addr=00000200", got_req, first_addr);
        end
        checks++;
        if (saw108 !== 1'b0) begin
            failures++; $display("FAIL redir_stale_delivered got=%b want=0", saw108);
        end
        checks++;
        if ({got_pc, inst} !== {1'b1, idata(32'h200)}) begin
            failures++; $display("FAIL redir_target_instr got seen=%b i=%h want i=%h", got_pc, inst, idata(32'h200));
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        mem_lat = 1;
        tick();  // request 0x100
        bus_if.stallD = 1'b1; bus_if.pcsrcE = 1'b1; bus_if.pctargetE = 32'h300;
        tick();  // response, stall and redirect together
        bus_if.stallD = 1'b0; bus_if.pcsrcE = 1'b0;
        checks++;
        if ({s_rv, s_req, bus_if.validD} !== 3'b100) begin
            failures++; $display("FAIL simul_cycle got rv=%b req=%b v=%b want rv=1 req=0 v=0", s_rv, s_req, bus_if.validD);
        end
        tick();
        checks++;
        if ({s_req, s_addr} !== {1'b1, 32'h300}) begin
            failures++; $display("FAIL simul_next_req got req=%b addr=%h want addr=00000300", s_req, s_addr);
        end
        tick();
        checks++;
        if ({bus_if.validD, bus_if.pcD, bus_if.instrD} !== {1'b1, 32'h300, idata(32'h300)}) begin
            failures++; $display("FAIL simul_ifid got v=%b pc=%h i=%h want pc=00000300 i=%h",
                                 bus_if.validD, bus_if.pcD, bus_if.instrD, idata(32'h300));
        end
    endtask

    task automatic test_flush();
        do_reset();
        mem_lat = 1;
        tick(); tick();
        bus_if.flushD = 1'b1; bus_if.stallD = 1'b1;
        tick();
        bus_if.flushD = 1'b0; bus_if.stallD = 1'b0;
        checks++;
        if ({bus_if.validD, bus_if.instrD, bus_if.pcD, bus_if.pcplus4D} !== {1'b0, NOP, 32'h0, 32'h0}) begin
            failures++; $display("FAIL flush_over_stall got v=%b i=%h pc=%h pc4=%h want v=0 i=%h pc=0 pc4=0",
                                 bus_if.validD, bus_if.instrD, bus_if.pcD, bus_if.pcplus4D, NOP);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        mem_lat = 1;
        tick();
        bus_if.pcsrcE = 1'b1; bus_if.pctargetE = 32'hFFFF_FFFC;
        tick();
        bus_if.pcsrcE = 1'b0;
        tick();
        checks++;
        if ({s_req, s_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            failures++; $display("FAIL wrap_req_top got req=%b addr=%h want addr=fffffffc", s_req, s_addr);
        end
        tick();
        checks++;
        if ({s_req, s_addr} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL wrap_req_zero got req=%b addr=%h want addr=00000000", s_req, s_addr);
        end
        checks++;
        if ({bus_if.validD, bus_if.pcD, bus_if.pcplus4D, bus_if.instrD} !== {1'b1, 32'hFFFF_FFFC, 32'h0, idata(32'hFFFF_FFFC)}) begin
            failures++; $display("FAIL wrap_ifid got v=%b pc=%h pc4=%h i=%h want pc=fffffffc pc4=0",
                                 bus_if.validD, bus_if.pcD, bus_if.pcplus4D, bus_if.instrD);
        end
    endtask

    // Random control/latency; expected stream: consecutive words from the last redirect.
    task automatic test_random();
        logic [31:0] exp_pc, exp_req;
        logic [31:0] p_pc, p_instr, p_pc4;
        logic        p_valid;
        int          delivered;
        do_reset();
        lat_rand  = 1'b1;
        exp_pc    = 32'h100;
        exp_req   = 32'h100;
        delivered = 0;
        for (int n = 0; n < 3000; n++) begin
            bus_if.stallD = ($urandom_range(0, 3) == 0);
            bus_if.pcsrcE = ($urandom_range(0, 19) == 0);
            bus_if.pctargetE = 32'h1000 + 32'($urandom_range(0, 63) << 2);
            bus_if.flushD = bus_if.pcsrcE && $urandom_range(0, 1) == 1;
            p_valid = bus_if.validD; p_pc = bus_if.pcD; p_instr = bus_if.instrD; p_pc4 = bus_if.pcplus4D;
            tick();
            if (s_req) begin
                checks++;
                if ({bus_if.pcsrcE, s_addr} !== {1'b0, exp_req}) begin
                    failures++; $display("FAIL rnd_req n=%0d got addr=%h redirect=%b want addr=%h redirect=0",
                                         n, s_addr, bus_if.pcsrcE, exp_req);
                end
                checks++;
                if (s_pend && !s_rv) begin
                    failures++; $display("FAIL rnd_outstanding n=%0d got second request want none", n);
                end
                exp_req = exp_req + 32'd4;
            end
            if (bus_if.flushD) begin
                checks++;
                if ({bus_if.validD, bus_if.instrD, bus_if.pcD, bus_if.pcplus4D} !== {1'b0, NOP, 32'h0, 32'h0}) begin
                    failures++; $display("FAIL rnd_flush n=%0d got v=%b pc=%h want bubble", n, bus_if.validD, bus_if.pcD);
                end
            end else if (bus_if.stallD) begin
                checks++;
                if ({bus_if.validD, bus_if.pcD, bus_if.instrD, bus_if.pcplus4D} !== {p_valid, p_pc, p_instr, p_pc4}) begin
                    failures++; $display("FAIL rnd_stall_hold n=%0d got v=%b pc=%h want v=%b pc=%h",
                                         n, bus_if.validD, bus_if.pcD, p_valid, p_pc);
                end
            end else if (bus_if.pcsrcE) begin
                checks++;
                if (bus_if.validD !== 1'b0) begin
                    failures++; $display("FAIL rnd_redirect_load n=%0d got v=%b want 0", n, bus_if.validD);
                end
            end else if (bus_if.validD) begin
                checks++;
                if ({bus_if.pcD, bus_if.instrD, bus_if.pcplus4D} !== {exp_pc, idata(exp_pc), exp_pc + 32'd4}) begin
                    failures++; $display("FAIL rnd_deliver n=%0d got pc=%h i=%h pc4=%h want pc=%h i=%h",
                                         n, bus_if.pcD, bus_if.instrD, bus_if.pcplus4D, exp_pc, idata(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (bus_if.pcsrcE) begin
                exp_pc  = bus_if.pctargetE;
                exp_req = bus_if.pctargetE;
            end
        end
        bus_if.stallD = 1'b0; bus_if.pcsrcE = 1'b0; bus_if.flushD = 1'b0;
        lat_rand = 1'b0;
        checks++;
        if (delivered < 200) begin
            failures++; $display("FAIL rnd_progress got delivered=%0d want >=200", delivered);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0; mem_lat = 1; lat_rand = 1'b0;
        bus_if.pcsrcE = 1'b0; bus_if.pctargetE = '0;
        bus_if.stallD = 1'b0; bus_if.flushD = 1'b0;
        bus_if.imem_rvalid = 1'b0; bus_if.imem_rdata = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_simultaneous();
        test_flush();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
